half_adder_unit: RTL and testbench

Bit-parallel half-adder array with a combinational result path and a one-cycle registered result path with valid tracking. Bit i computes sum[i] = a[i] ^ b[i] and c_out[i] = a[i] & b[i]. There is no carry chain between bits. It is the leaf cell of the ALU adder hierarchy: full adders and ripple and carry-lookahead adders are composed from it. With the default WIDTH = 1 and the clock and reset tied off, it behaves as the classic 1-bit combinational half adder.

---
 rtl/half_adder_pkg.sv | 21 ++
 rtl/half_adder_bit.sv | 12 +
 rtl/half_adder_unit.sv | 81 ++++++++
 tb/tb_half_adder_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder_unit slice: lane limit,
// carry popcount and reset values of the registered outputs.
package half_adder_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int POP_W     = 7;

  localparam logic [MAX_WIDTH-1:0] RST_SUM   = '0;
  localparam logic [MAX_WIDTH-1:0] RST_CARRY = '0;
  localparam logic                 RST_VALID = 1'b0;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n = n + {{(POP_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_bit.sv
// One combinational half-adder lane: sum = a ^ b, c_out = a & b.
module half_adder_bit (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b;
  assign c_out = a & b;

endmodule

// File: rtl/half_adder_unit.sv
// WIDTH independent half-adder lanes with a combinational result and a
// one-cycle registered result; optional carry counter under HALF_ADDER_CARRY_CNT_EN.
module half_adder_unit
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] c_out_q,
  output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || CNT_W < 1) begin : g_bad_param
    $error("half_adder_unit: WIDTH must be 1..64 and CNT_W at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .sum  (sum[i]),
      .c_out(c_out[i])
    );
  end

  // Valid semantics: in_valid qualifies a/b for capture on each rising edge;
  // out_valid is in_valid delayed one cycle. There is no ready: every valid
  // pair is accepted, and the result registers hold while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= RST_SUM[WIDTH-1:0];
      c_out_q   <= RST_CARRY[WIDTH-1:0];
      out_valid <= RST_VALID;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        c_out_q <= c_out;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  localparam int SUM_W = CNT_W + POP_W + 1;

  logic [MAX_WIDTH-1:0] carry_pad;
  logic [SUM_W-1:0]     cnt_sum;
  logic [CNT_W-1:0]     cnt_next;

  always_comb begin
    carry_pad              = '0;
    carry_pad[WIDTH-1:0]   = c_out;
    cnt_sum  = {{(POP_W+1){1'b0}}, carry_cnt}
             + {{(CNT_W+1){1'b0}}, popcount(carry_pad)};
    // Clamp to all-ones rather than letting the count wrap.
    cnt_next = (cnt_sum > {{(POP_W+1){1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                               : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (in_valid) begin
      carry_cnt <= cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// Directed bench for half_adder_unit: three instances (WIDTH 1, 8, 4) share
// clock and reset; the carry counter is exercised when HALF_ADDER_CARRY_CNT_EN is set.
module tb_half_adder_unit;

  int checks = 0;
  int errors = 0;

  // ---- clock / reset ----
  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic clk_run = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  // ---- DUT signals ----
  logic       a1, b1, iv1, s1, c1, sq1, cq1, ov1;
  logic [7:0] a8, b8, s8, c8, sq8, cq8;
  logic       iv8, ov8;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic       iv4, ov4;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0] cnt1, cnt8;
  logic [3:0]  cnt4;
`endif

  half_adder_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
    .sum(s1), .c_out(c1), .sum_q(sq1), .c_out_q(cq1), .out_valid(ov1)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt1)
`endif
  );

  half_adder_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8),
    .sum(s8), .c_out(c8), .sum_q(sq8), .c_out_q(cq8), .out_valid(ov8)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt8)
`endif
  );

  half_adder_unit #(.WIDTH(4), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4),
    .sum(s4), .c_out(c4), .sum_q(sq4), .c_out_q(cq4), .out_valid(ov4)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt4)
`endif
  );

  // ---- checker ----
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- directed stimulus ----
  initial begin
    a1 = 0; b1 = 0; iv1 = 0;
    a8 = '0; b8 = '0; iv8 = 0;
    a4 = '0; b4 = '0; iv4 = 0;

    #1 rst = 1'b1;
    #1;
    check("rst_sum_q",     64'(sq8), 64'h0);
    check("rst_c_out_q",   64'(cq8), 64'h0);
    check("rst_out_valid", 64'(ov8), 64'h0);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("rst_carry_cnt", 64'(cnt4), 64'h0);
`endif

    // WIDTH=1 truth table, clock idle, reset held (comb path ignores both)
    a1 = 0; b1 = 0; #10;
    check("w1_00_sum", 64'(s1), 64'h0); check("w1_00_cout", 64'(c1), 64'h0);
    a1 = 0; b1 = 1; #10;
    check("w1_01_sum", 64'(s1), 64'h1); check("w1_01_cout", 64'(c1), 64'h0);
    a1 = 1; b1 = 0; #10;
    check("w1_10_sum", 64'(s1), 64'h1); check("w1_10_cout", 64'(c1), 64'h0);
    a1 = 1; b1 = 1; #10;
    check("w1_11_sum", 64'(s1), 64'h0); check("w1_11_cout", 64'(c1), 64'h1);

    // Lane isolation
    a4 = 4'hF; b4 = 4'hF; #1;
    check("w4_iso_sum",  64'(s4), 64'h0);
    check("w4_iso_cout", 64'(c4), 64'hF);
    a4 = 4'hA; b4 = 4'h3; #1;
    check("w4_mix_sum",  64'(s4), 64'h9);
    check("w4_mix_cout", 64'(c4), 64'h2);

    // Start the clock, release reset between edges
    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Registered capture
    a8 = 8'hF0; b8 = 8'h3C; iv8 = 1;
    @(negedge clk);
    check("w8_cap_sum_q",   64'(sq8), 64'hCC);
    check("w8_cap_c_out_q", 64'(cq8), 64'h30);
    check("w8_cap_valid",   64'(ov8), 64'h1);

    // Hold when in_valid low, even though operands change
    iv8 = 0; a8 = 8'hFF; b8 = 8'h01;
    @(negedge clk);
    check("w8_hold_valid",   64'(ov8), 64'h0);
    check("w8_hold_sum_q",   64'(sq8), 64'hCC);
    check("w8_hold_c_out_q", 64'(cq8), 64'h30);
    check("w8_comb_sum",     64'(s8),  64'hFE);
    check("w8_comb_cout",    64'(c8),  64'h01);

    // Second capture, then asynchronous reset between edges
    a8 = 8'h55; b8 = 8'hFF; iv8 = 1;
    @(negedge clk);
    check("w8_cap2_sum_q",   64'(sq8), 64'hAA);
    check("w8_cap2_c_out_q", 64'(cq8), 64'h55);
    check("w8_cap2_valid",   64'(ov8), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("async_sum_q",     64'(sq8), 64'h0);
    check("async_c_out_q",   64'(cq8), 64'h0);
    check("async_valid",     64'(ov8), 64'h0);
    check("async_comb_sum",  64'(s8),  64'hAA);
    check("async_comb_cout", 64'(c8),  64'h55);

    // Reset wins over a clock edge with in_valid high
    @(negedge clk);
    check("rst_hold_valid", 64'(ov8), 64'h0);
    check("rst_hold_sum_q", 64'(sq8), 64'h0);

    // Resume on the first edge after release
    rst = 1'b0;
    a8 = 8'h0F; b8 = 8'h0F;
    @(negedge clk);
    check("resume_sum_q",   64'(sq8), 64'h00);
    check("resume_c_out_q", 64'(cq8), 64'h0F);
    check("resume_valid",   64'(ov8), 64'h1);
    iv8 = 0;

    // WIDTH=4 registered path and carry counter
    a4 = 4'hF; b4 = 4'hF; iv4 = 1;
    @(negedge clk);
    check("w4_sum_q",   64'(sq4), 64'h0);
    check("w4_c_out_q", 64'(cq4), 64'hF);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("cnt_1", 64'(cnt4), 64'd4);
    @(negedge clk); check("cnt_2", 64'(cnt4), 64'd8);
    @(negedge clk); check("cnt_3", 64'(cnt4), 64'd12);
    @(negedge clk); check("cnt_4_sat", 64'(cnt4), 64'd15);
    @(negedge clk); check("cnt_5_sat", 64'(cnt4), 64'd15);
    iv4 = 0;
    #2 rst = 1'b1;
    #1 check("cnt_rst", 64'(cnt4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif
    iv4 = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
